// File: rtl/lpm_mac_pkg.sv
// Shared types and helpers for the lpm_mac_acc multiply-accumulate slice.
// LPM_MAC_SATURATE_EN selects clamping instead of wrapping on accumulator overflow.
package lpm_mac_pkg;

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned WIDE_W    = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    wide_t sum;
    logic  ovf;
  } add_res_t;

  function automatic wide_t acc_max(input int unsigned w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t acc_min(input int unsigned w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  localparam wide_t ACC_MAX = acc_max(ACC_W_DEF);
  localparam wide_t ACC_MIN = acc_min(ACC_W_DEF);

  // The exact sum fits in WIDE_W, so "outside the w-bit range" is the same
  // test as "operands share a sign and the w-bit sum sign differs".
  function automatic add_res_t sat_add(input wide_t acc, input wide_t prod,
                                       input int unsigned w);
    wide_t    raw;
    wide_t    hi;
    wide_t    lo;
    add_res_t r;
    raw   = acc + prod;
    hi    = acc_max(w);
    lo    = acc_min(w);
    r.ovf = (raw > hi) || (raw < lo);
`ifdef LPM_MAC_SATURATE_EN
    if (raw > hi)      r.sum = hi;
    else if (raw < lo) r.sum = lo;
    else               r.sum = raw;
`else
    r.sum = (raw <<< (WIDE_W - w)) >>> (WIDE_W - w);
`endif
    return r;
  endfunction

endpackage

// File: rtl/lpm_mac_acc_mul_stage.sv
// Registered signed multiply with optional negate; carries a valid bit alongside.
module lpm_mac_mul_stage #(
  parameter int DATA_W = 11
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic signed [DATA_W-1:0]       in_a,
  input  logic signed [DATA_W-1:0]       in_b,
  input  logic                           in_sub,
  output logic                           out_valid,
  output logic signed [2*DATA_W-1:0]     out_prod
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = in_a * in_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_prod <= in_sub ? -prod : prod;
    end
  end

endmodule

// File: rtl/lpm_mac_acc.sv
// Pipelined signed MAC: accumulates VEC_LEN products, holds the sum until drained.
// Define LPM_MAC_SATURATE_EN to clamp on overflow; default wraps two's-complement.
module lpm_mac_acc
  import lpm_mac_pkg::*;
#(
  parameter int DATA_W  = 11,
  parameter int ACC_W   = 24,
  parameter int VEC_LEN = 4,
  parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_result,
  output logic                     out_overflow
);

  state_t                     state;
  logic [CNT_W-1:0]           issued;
  logic [CNT_W-1:0]           issued_nxt;
  logic [CNT_W-1:0]           done;
  logic                       rdy;
  logic                       accept;
  logic                       mvalid;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic                       ovf;
  add_res_t                   add;

  assign in_ready     = rdy;
  assign accept       = in_valid && rdy;
  assign issued_nxt   = issued + CNT_W'(accept);
  assign add          = sat_add(wide_t'(acc), wide_t'(prod), ACC_W);
  assign out_result   = acc;
  assign out_overflow = ovf;

  lpm_mac_mul_stage #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (mvalid),
    .out_prod  (prod)
  );

  // in_ready is registered from the next-state counters so it never sees in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      issued    <= '0;
      done      <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      rdy       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          issued <= issued_nxt;
          rdy    <= issued_nxt < CNT_W'(VEC_LEN);
          if (mvalid) begin
            acc  <= add.sum[ACC_W-1:0];
            ovf  <= ovf | add.ovf;
            done <= done + CNT_W'(1);
            if (done == CNT_W'(VEC_LEN - 1)) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            issued    <= '0;
            done      <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            rdy       <= 1'b1;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpm_mac_acc.sv
// Scoreboard bench for lpm_mac_acc: driver pushes model results, monitor pops on handshake.
module tb_lpm_mac_acc;

  localparam int DATA_W = 11;
  localparam int ACC_W  = 24;
  localparam int VEC_LEN = 4;
  localparam longint AMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (ACC_W - 1));
  localparam longint AMOD = longint'(1) <<< ACC_W;

  logic clk, rst;
  logic in_valid, in_ready, in_sub, out_valid, out_ready, out_overflow;
  logic signed [DATA_W-1:0] in_a, in_b;
  logic signed [ACC_W-1:0]  out_result;

  logic v16, r16, sub16, ov16, ordy16, ovf16;
  logic signed [DATA_W-1:0] a16, b16;
  logic signed [ACC_W-1:0]  res16;

  typedef struct {
    longint res;
    bit     ovf;
  } exp_t;

  exp_t   sbq[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     last_acc = -100;
  bit     prev_ov = 0;
  longint m_acc = 0;
  bit     m_ovf = 0;
  int     m_cnt = 0;

  lpm_mac_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .VEC_LEN(VEC_LEN)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_overflow(out_overflow)
  );

  lpm_mac_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .VEC_LEN(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
    .in_a(a16), .in_b(b16), .in_sub(sub16), .out_valid(ov16),
    .out_ready(ordy16), .out_result(res16), .out_overflow(ovf16)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, then range rule and wrap/clamp.
  task automatic model_step(inout longint acc, inout bit ovf,
                            input int a, input int b, input bit sub);
    longint p, s;
    p = longint'(a) * longint'(b);
    if (sub) p = -p;
    s = acc + p;
    if (s > AMAX || s < AMIN) begin
      ovf = 1;
`ifdef LPM_MAC_SATURATE_EN
      s = (s > AMAX) ? AMAX : AMIN;
`else
      s = ((((s - AMIN) % AMOD) + AMOD) % AMOD) + AMIN;
`endif
    end
    acc = s;
  endtask

  task automatic send(input int a, input int b, input bit sub, input int gap);
    int n;
    n = 0;
    in_a = DATA_W'(a);
    in_b = DATA_W'(b);
    in_sub = sub;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_a = DATA_W'($urandom);
    in_b = DATA_W'($urandom);
    in_sub = 1'($urandom);
    if (n < 50) begin
      model_step(m_acc, m_ovf, a, b, sub);
      m_cnt++;
      if (m_cnt == VEC_LEN) begin
        sbq.push_back('{m_acc, m_ovf});
        m_acc = 0;
        m_ovf = 0;
        m_cnt = 0;
      end
    end
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_wait", out_valid, 1);
    repeat (hold) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    @(negedge clk);
    check("post_drain_in_ready", in_ready, 1);
    check("post_drain_valid", out_valid, 0);
    check("post_drain_result", out_result, 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency from last accept, and scoreboard compare on each handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 0;
      end else begin
        if (in_valid && in_ready) last_acc = cyc;
        if (out_valid && !prev_ov) check("latency", cyc - last_acc, 2);
        if (out_valid && out_ready) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got result %0d with no expected entry", out_result);
          end else begin
            checks--;
            e = sbq.pop_front();
            check("result", out_result, e.res);
            check("overflow", out_overflow, e.ovf);
          end
        end
        prev_ov = out_valid;
      end
      cyc++;
    end
  end

  initial begin
    int n, cnt;
    longint acc16;
    bit ovf16_m;
    rst = 1; in_valid = 0; in_a = '0; in_b = '0; in_sub = 0; out_ready = 0;
    v16 = 0; a16 = '0; b16 = '0; sub16 = 0; ordy16 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_overflow", out_overflow, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    repeat (4) send(3, 5, 0, 0);
    drain(0);

    send(10, 10, 0, 0);
    send(7, 3, 1, 0);
    send(-1024, -1024, 0, 0);
    send(-1024, 1023, 1, 0);
    drain(1);

    // Backpressure with extra beats offered during HOLD.
    repeat (4) send(int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024, 1'($urandom), 0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      if (sbq.size() > 0) begin
        check("bp_result", out_result, sbq[0].res);
        check("bp_overflow", out_overflow, sbq[0].ovf);
      end
    end
    in_valid = 0;
    drain(0);

    repeat (4) send(2, 2, 0, 3);
    drain(2);

    send(5, 6, 0, 0);
    send(7, 8, 0, 0);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    m_acc = 0; m_ovf = 0; m_cnt = 0;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_result", out_result, 0);
    check("midrst_overflow", out_overflow, 0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    repeat (4) send(1, 1, 0, 0);
    drain(0);

    for (int v = 0; v < 12; v++) begin
      for (int k = 0; k < VEC_LEN; k++)
        send(int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024,
             1'($urandom), int'($urandom_range(2)));
      drain(int'($urandom_range(3)));
    end

    // Long vector on the second instance drives the accumulator past its range.
    acc16 = 0; ovf16_m = 0; cnt = 0; n = 0;
    a16 = -11'sd1024; b16 = -11'sd1024; sub16 = 0; v16 = 1;
    while (cnt < 16 && n < 200) begin
      @(negedge clk);
      n++;
      if (r16) begin
        cnt++;
        model_step(acc16, ovf16_m, -1024, -1024, 0);
      end
      @(posedge clk);
      #1;
    end
    v16 = 0;
    check("ovf_beats", cnt, 16);
    n = 0;
    @(negedge clk);
    while (!ov16 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ovf_valid", ov16, 1);
    check("ovf_result", res16, acc16);
    check("ovf_flag", ovf16, ovf16_m);
    @(posedge clk);
    #1;
    ordy16 = 1;
    @(posedge clk);
    #1;
    ordy16 = 0;
    @(negedge clk);
    check("ovf_cleared", ovf16, 0);
    check("ovf_acc_cleared", res16, 0);

    check("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lpm_mac_acc.md
Name: lpm_mac_acc

Overview:
- Parametrised, pipelined signed multiply-accumulate unit for the MatrixMult datapath.
- Successor to the plain combinational LPM adder: adds a multiply stage, add/subtract mode, a per-vector element counter, a valid/ready handshake on both sides, and a sticky signed-overflow flag.
- Accumulates VEC_LEN products (one dot-product term per beat), presents the sum, then clears for the next vector.

Parameters:
- DATA_W, 11, signed width of each input operand.
- ACC_W, 24, signed accumulator/result width; must be >= 2*DATA_W.
- VEC_LEN, 4, number of products per accumulated vector; must be >= 1.
- CNT_W, $clog2(VEC_LEN+1), element counter width. Derived; do not override.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  DATA_W  signed operand A.
- in_b  in  DATA_W  signed operand B.
- in_sub  in  1  1 = subtract a*b from accumulator; 0 = add.
- out_valid  out  1  out_result holds a completed vector sum.
- out_ready  in  1  consumer accepts the result.
- out_result  out  ACC_W  signed accumulated sum.
- out_overflow  out  1  sticky: set if any accumulation in this vector overflowed ACC_W.

Behaviour:
- Reset values: in_ready=0 during rst, 1 on the first cycle after; out_valid=0, out_result=0, out_overflow=0. Accumulator, counters and pipeline valids are 0. State is ACCUM.
- Accept: a beat is taken when in_valid && in_ready.
- in_ready = (state==ACCUM) && (issued < VEC_LEN). It is decoded from registered state only and never depends on in_valid.
- Stage 1, registered: prod = in_a*in_b, full 2*DATA_W signed. It is negated when in_sub=1; negation cannot overflow at 2*DATA_W.
- Stage 2, registered:
  - Sign-extend prod to ACC_W+1 bits and add it to the sign-extended accumulator.
  - Overflow rule: both operands share a sign and the ACC_W-bit sum sign differs. When it fires, set sticky overflow.
- Counters: issued increments on each accept; done increments as each product is accumulated.
- When done reaches VEC_LEN, the state moves to HOLD.
- Latency: last beat accepted at cycle t, out_valid=1 at t+2. Non-final beats produce no output.
- HOLD:
  - out_valid=1; out_result and out_overflow are stable.
  - in_ready=0.
  - Held indefinitely while out_ready=0.
- Handshake out_valid && out_ready:
  - Next cycle: accumulator, counters and sticky flag cleared, out_valid=0, state ACCUM, in_ready=1.
  - The handshake cycle itself has in_ready=0, so no new beat can overlap the drain.
- Input bubbles (in_valid=0) are allowed anywhere mid-vector; the accumulator holds.
- in_a, in_b and in_sub are ignored when no accept occurs.
- VEC_LEN=1: every beat yields a result after 2 cycles, then the unit waits for the drain.
- rst mid-vector or in HOLD: all state is discarded and the unit returns to reset values on the next edge. The in-flight product is dropped.

Optional Feature:
- Macro: LPM_MAC_SATURATE_EN.
- Defined: on overflow the accumulator clamps to +max (2^(ACC_W-1)-1) or -min (-2^(ACC_W-1)), chosen by operand sign. out_overflow is still set. Later adds continue from the clamped value.
- Undefined: two's-complement wrap to ACC_W bits; out_overflow is still set.

Decomposition:
- Package lpm_mac_pkg holds:
  - state enum {ACCUM, HOLD};
  - function sat_add(acc, prod) returning the sum plus an overflow bit;
  - localparams ACC_MAX and ACC_MIN, computed from ACC_W.
- One sub-module is natural: lpm_mac_mul_stage, the registered signed multiply with optional negate and a valid pipe bit.
- Counters, FSM and accumulator stay in the top module.

Test Plan:
- Basic: defaults; 4 beats of a=3, b=5, in_sub=0 on back-to-back cycles -> out_valid exactly 2 cycles after the 4th accept; out_result=60; out_overflow=0.
- Mixed sign/sub: beats (10,10,add), (7,3,sub), (-1024,-1024,add), (-1024,1023,sub) -> out_result = 100 - 21 + 1048576 + 1047552 = 2096207; overflow=0.
- Overflow: VEC_LEN=16, 16 beats of (-1024,-1024,add).
  - Wrap build -> out_result=0, out_overflow=1.
  - LPM_MAC_SATURATE_EN build -> out_result=8388607, out_overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flag stable, in_ready=0 throughout, extra in_valid beats not accepted. Raise out_ready -> in_ready=1 the following cycle and the accumulator restarts from 0.
- Bubbles: 4 beats of (2,2,add) with 3 idle cycles between beats -> out_result=16; latency measured from the last accept is still 2.
- Reset mid-vector: accept 2 beats, assert rst for 1 cycle -> all outputs 0. A following 4-beat vector of (1,1,add) -> out_result=4, with no carry-over.
